// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction sequencer for the 16-bit RISC datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature macro: ILLEGAL_TRAP_EN adds a HALT state and the illegal_op output.
//
// state  | meaning
// FETCH  | request instruction word, load IR and advance PC on imem_ready
// DECODE | register read, no strobes
// EXEC   | ALU operation, branch/jump resolution
// MEM    | data memory read (LD) or write (ST) until dmem_ready
// WB     | register file write-back
// HALT   | undefined opcode trap, left only by reset (ILLEGAL_TRAP_EN)
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       mem_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef ILLEGAL_TRAP_EN
    ,
    ST_HALT
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_LD,
    CLS_ST,
    CLS_R,
    CLS_BEQ,
    CLS_BNE,
    CLS_JMP,
    CLS_ILL
  } op_class_t;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MEM_WAIT_MAX);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  op_class_t         op_class;
  logic              timeout;

  always_comb begin
    op_class = CLS_R;
    case (opcode)
      4'b0000: op_class = CLS_LD;
      4'b0001: op_class = CLS_ST;
      4'b1011: op_class = CLS_BEQ;
      4'b1100: op_class = CLS_BNE;
      4'b1101: op_class = CLS_JMP;
      4'b1010,
      4'b1111: op_class = CLS_ILL;
      default: op_class = CLS_R;
    endcase
  end

  assign timeout = (wait_cnt_q == WAIT_MAX_C);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    alu_op     = ALU_RTYPE;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          imem_req   = 1'b1;
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SEQ;
          wait_cnt_d = '0;
          state_d    = ST_DECODE;
        end else if (timeout) begin
          // Abort without touching PC/IR; the same PC is refetched.
          mem_err    = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_FETCH;
        end else begin
          imem_req   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        wait_cnt_d = '0;
        case (op_class)
          CLS_LD, CLS_ST: begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
            state_d = ST_MEM;
          end
          CLS_R: begin
            alu_op  = ALU_RTYPE;
            state_d = ST_WB;
          end
          CLS_BEQ: begin
            alu_op     = ALU_SUB;
            pc_src     = PC_BRANCH;
            pc_write   = zero_flag;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_BNE: begin
            alu_op     = ALU_SUB;
            pc_src     = PC_BRANCH;
            pc_write   = ~zero_flag;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_JMP: begin
            pc_src     = PC_JUMP;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d    = ST_HALT;
`else
            instr_done = 1'b1;
            state_d    = ST_FETCH;
`endif
          end
        endcase
      end

      ST_MEM: begin
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        if (dmem_ready) begin
          mem_read   = (op_class == CLS_LD);
          mem_write  = (op_class == CLS_ST);
          wait_cnt_d = '0;
          if (op_class == CLS_LD) begin
            state_d = ST_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        end else if (timeout) begin
          // Request drops on the abort cycle, so a timed-out store never lands.
          mem_err    = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_FETCH;
        end else begin
          mem_read   = (op_class == CLS_LD);
          mem_write  = (op_class == CLS_ST);
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
        if (op_class == CLS_LD) begin
          mem_to_reg = 1'b1;
          reg_dst    = 1'b0;
        end else begin
          mem_to_reg = 1'b0;
          reg_dst    = 1'b1;
        end
      end

`ifdef ILLEGAL_TRAP_EN
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif

      default: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
    endcase

    // Outputs are quiet during the reset cycle regardless of current state.
    if (reset) begin
      imem_req   = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      alu_op     = ALU_RTYPE;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      mem_err    = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == ST_HALT) && !reset;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
